chkpt_ctrl: RTL and testbench
=============================

CHKPT_CTRL -- requirements
Module: chkpt_ctrl

Interface
REQ-001 Parameter: NUM_PAGES, 8, number of shadow checkpoint pages.
REQ-002 Parameter: NUM_CHUNKS, 8, copy beats per page (128 entries / 16 lanes).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 save_req  input  1  request checkpoint of main table; level, held until save_ack.
REQ-006 save_ack  output  1  one-cycle pulse: checkpoint complete.
REQ-007 save_page  output  3  allocated page id; valid only while save_ack=1.
REQ-008 restore_req  input  1  one-cycle pulse: restore main table from restore_page.
REQ-009 restore_page  input  3  page to restore; sampled with restore_req.
REQ-010 restore_done  output  1  one-cycle pulse: restore complete.
REQ-011 restore_err  output  1  one-cycle pulse: restore_req named a page not in VALID state.
REQ-012 release_req  input  1  one-cycle pulse: free release_page.
REQ-013 release_page  input  3  page to free; sampled with release_req.
REQ-014 flush  input  1  one-cycle pulse: free all pages, abort any copy.
REQ-015 cp_we  output  1  shadow write strobe (main -> shadow page cp_page, chunk cp_chunk).
REQ-016 cp_re  output  1  restore strobe (shadow page cp_page, chunk cp_chunk -> main).
REQ-017 cp_page  output  3  page addressed by current copy beat.
REQ-018 cp_chunk  output  3  chunk index of current copy beat.
REQ-019 main_stall  output  1  freeze main table pointer/writes; high whenever state != IDLE.
REQ-020 full  output  1  no FREE page; free_count  output  4  number of FREE pages (0..8).

Function
REQ-021 Each page SHALL be FREE, SAVING or VALID, tracked by alloc and valid bitmaps.
REQ-022 FSM states SHALL be IDLE, SAVE, RESTORE; priority in IDLE: flush > restore_req > save_req.
REQ-023 IDLE, save_req=1, full=0: allocate lowest-numbered FREE page, mark SAVING, go SAVE.
REQ-024 SAVE: cp_we=1, cp_chunk counts 0..NUM_CHUNKS-1 on consecutive cycles; cycle after chunk 7 save_ack=1 with save_page, page -> VALID, state -> IDLE.
REQ-025 Save latency: accept edge N, cp_we cycles N+1..N+8, save_ack cycle N+9.
REQ-026 save_req with full=1 SHALL stall (no ack, no allocation) until a page frees.
REQ-027 IDLE, restore_req to VALID page: go RESTORE, cp_re=1 for chunks 0..7, then restore_done pulse and IDLE; page stays VALID.
REQ-028 restore_req to FREE/SAVING page: restore_err pulse next cycle, no state change.
REQ-029 restore_req during SAVE: abort save (page -> FREE, no save_ack), enter RESTORE next cycle if target VALID.
REQ-030 restore_req during RESTORE: ignored.
REQ-031 release_req in any state: VALID page -> FREE; FREE or SAVING page unaffected.
REQ-032 Same-cycle release and allocation: allocation SHALL use pre-release bitmap.
REQ-033 flush: all pages FREE, state IDLE, no ack/done pulse; flush wins over all same-cycle requests.
REQ-034 full and free_count SHALL be registered, consistent with bitmaps after each edge.
REQ-035 cp_we, cp_re never both high; cp_page/cp_chunk = 0 when neither high.

Reset
REQ-036 On reset: state IDLE, all pages FREE, free_count=8, full=0, all pulse/strobe outputs 0, cp_page=cp_chunk=0.
REQ-037 Reset mid-copy SHALL abandon the copy with no ack/done.

Structure
REQ-038 chkpt_pkg SHALL hold NUM_PAGES, NUM_CHUNKS, page-id width, and the FSM state enum.
REQ-039 Lowest-free-page search SHALL be sub-module chkpt_alloc (priority encoder, found flag).

Verification
REQ-040 Reset, save_req held -> cp_we chunks 0..7, save_ack on 9th cycle, save_page=0, free_count=7.
REQ-041 Nine back-to-back saves -> pages 0..7 acked, full=1, 9th stalls; release page 3 -> 9th acks with save_page=3.
REQ-042 Save page 0, restore_req page 0 -> cp_re chunks 0..7 page 0, restore_done; restore_req page 5 (FREE) -> restore_err.
REQ-043 restore_req at chunk 4 of save to page 1 -> no save_ack, page 1 FREE, restore of VALID page 0 proceeds.
REQ-044 flush during SAVE with 4 VALID pages -> IDLE next cycle, free_count=8, no ack.
REQ-045 reset asserted at chunk 2 of RESTORE -> outputs zero immediately, no restore_done.

Source files
------------

// File: rtl/chkpt_pkg.sv
// Shared sizing constants and FSM state encoding for the checkpoint controller.
package chkpt_pkg;

  localparam int unsigned NUM_PAGES  = 8;
  localparam int unsigned NUM_CHUNKS = 8;
  localparam int unsigned PAGE_W     = $clog2(NUM_PAGES);
  localparam int unsigned CHUNK_W    = $clog2(NUM_CHUNKS);
  localparam int unsigned COUNT_W    = $clog2(NUM_PAGES + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAVE,
    ST_RESTORE
  } state_e;

endpackage

// File: rtl/chkpt_alloc.sv
// Lowest-numbered free page finder: priority encoder over the allocation bitmap.
module chkpt_alloc
  import chkpt_pkg::*;
#(
  parameter int unsigned PAGES = NUM_PAGES
) (
  input  logic [PAGES-1:0]  alloc,
  output logic [PAGE_W-1:0] free_idx,
  output logic              found
);

  // Scan downwards so the lowest free page is the last one to win.
  always_comb begin
    free_idx = '0;
    found    = 1'b0;
    for (int unsigned i = PAGES; i > 0; i--) begin
      if (!alloc[i-1]) begin
        free_idx = PAGE_W'(i - 1);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/chkpt_ctrl.sv
// Checkpoint controller: allocates shadow pages, sequences save/restore copy
// beats between the main table and shadow pages, and tracks page lifetime.
module chkpt_ctrl #(
  parameter int unsigned NUM_PAGES  = chkpt_pkg::NUM_PAGES,
  parameter int unsigned NUM_CHUNKS = chkpt_pkg::NUM_CHUNKS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          save_req,
  output logic                          save_ack,
  output logic [chkpt_pkg::PAGE_W-1:0]  save_page,
  input  logic                          restore_req,
  input  logic [chkpt_pkg::PAGE_W-1:0]  restore_page,
  output logic                          restore_done,
  output logic                          restore_err,
  input  logic                          release_req,
  input  logic [chkpt_pkg::PAGE_W-1:0]  release_page,
  input  logic                          flush,
  output logic                          cp_we,
  output logic                          cp_re,
  output logic [chkpt_pkg::PAGE_W-1:0]  cp_page,
  output logic [chkpt_pkg::CHUNK_W-1:0] cp_chunk,
  output logic                          main_stall,
  output logic                          full,
  output logic [chkpt_pkg::COUNT_W-1:0] free_count
);

  import chkpt_pkg::*;

  state_e               state_q, state_d;
  logic [NUM_PAGES-1:0] alloc_q, alloc_d;
  logic [NUM_PAGES-1:0] valid_q, valid_d;
  logic [PAGE_W-1:0]    cp_page_q, cp_page_d;
  logic [CHUNK_W-1:0]   cp_chunk_q, cp_chunk_d;
  logic                 cp_we_q, cp_we_d;
  logic                 cp_re_q, cp_re_d;
  logic                 save_ack_q, save_ack_d;
  logic [PAGE_W-1:0]    save_page_q, save_page_d;
  logic                 restore_done_q, restore_done_d;
  logic                 restore_err_q, restore_err_d;
  logic                 main_stall_q, main_stall_d;
  logic                 full_q, full_d;
  logic [COUNT_W-1:0]   free_count_q, free_count_d;

  logic [PAGE_W-1:0]    free_idx;
  logic                 free_found;
  logic                 restore_hit;
  logic                 last_chunk;

  // Allocation looks at the registered bitmap, so a same-cycle release is not yet visible.
  chkpt_alloc #(.PAGES(NUM_PAGES)) u_alloc (
    .alloc    (alloc_q),
    .free_idx (free_idx),
    .found    (free_found)
  );

  assign restore_hit = valid_q[restore_page] &&
                       !(release_req && (release_page == restore_page));
  assign last_chunk  = (cp_chunk_q == CHUNK_W'(NUM_CHUNKS - 1));

  always_comb begin
    state_d        = state_q;
    alloc_d        = alloc_q;
    valid_d        = valid_q;
    cp_page_d      = cp_page_q;
    cp_chunk_d     = cp_chunk_q;
    cp_we_d        = 1'b0;
    cp_re_d        = 1'b0;
    save_ack_d     = 1'b0;
    save_page_d    = '0;
    restore_done_d = 1'b0;
    restore_err_d  = 1'b0;

    if (release_req && valid_q[release_page]) begin
      valid_d[release_page] = 1'b0;
      alloc_d[release_page] = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (restore_req) begin
          if (restore_hit) begin
            state_d    = ST_RESTORE;
            cp_re_d    = 1'b1;
            cp_page_d  = restore_page;
            cp_chunk_d = '0;
          end else begin
            restore_err_d = 1'b1;
          end
        end else if (save_req && free_found) begin
          alloc_d[free_idx] = 1'b1;
          state_d           = ST_SAVE;
          cp_we_d           = 1'b1;
          cp_page_d         = free_idx;
          cp_chunk_d        = '0;
        end
      end
      ST_SAVE: begin
        if (restore_req) begin
          // Abandon the partial shadow copy before switching to the restore.
          alloc_d[cp_page_q] = 1'b0;
          if (restore_hit) begin
            state_d    = ST_RESTORE;
            cp_re_d    = 1'b1;
            cp_page_d  = restore_page;
            cp_chunk_d = '0;
          end else begin
            restore_err_d = 1'b1;
            state_d       = ST_IDLE;
            cp_page_d     = '0;
            cp_chunk_d    = '0;
          end
        end else if (last_chunk) begin
          valid_d[cp_page_q] = 1'b1;
          save_ack_d         = 1'b1;
          save_page_d        = cp_page_q;
          state_d            = ST_IDLE;
          cp_page_d          = '0;
          cp_chunk_d         = '0;
        end else begin
          cp_we_d    = 1'b1;
          cp_chunk_d = cp_chunk_q + CHUNK_W'(1);
        end
      end
      ST_RESTORE: begin
        if (last_chunk) begin
          restore_done_d = 1'b1;
          state_d        = ST_IDLE;
          cp_page_d      = '0;
          cp_chunk_d     = '0;
        end else begin
          cp_re_d    = 1'b1;
          cp_chunk_d = cp_chunk_q + CHUNK_W'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        cp_page_d  = '0;
        cp_chunk_d = '0;
      end
    endcase

    if (flush) begin
      state_d        = ST_IDLE;
      alloc_d        = '0;
      valid_d        = '0;
      cp_page_d      = '0;
      cp_chunk_d     = '0;
      cp_we_d        = 1'b0;
      cp_re_d        = 1'b0;
      save_ack_d     = 1'b0;
      save_page_d    = '0;
      restore_done_d = 1'b0;
      restore_err_d  = 1'b0;
    end

    main_stall_d = (state_d != ST_IDLE);
  end

  always_comb begin
    free_count_d = '0;
    for (int unsigned i = 0; i < NUM_PAGES; i++) begin
      free_count_d = free_count_d + COUNT_W'(~alloc_d[i]);
    end
    full_d = &alloc_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      alloc_q        <= '0;
      valid_q        <= '0;
      cp_page_q      <= '0;
      cp_chunk_q     <= '0;
      cp_we_q        <= 1'b0;
      cp_re_q        <= 1'b0;
      save_ack_q     <= 1'b0;
      save_page_q    <= '0;
      restore_done_q <= 1'b0;
      restore_err_q  <= 1'b0;
      main_stall_q   <= 1'b0;
      full_q         <= 1'b0;
      free_count_q   <= COUNT_W'(NUM_PAGES);
    end else begin
      state_q        <= state_d;
      alloc_q        <= alloc_d;
      valid_q        <= valid_d;
      cp_page_q      <= cp_page_d;
      cp_chunk_q     <= cp_chunk_d;
      cp_we_q        <= cp_we_d;
      cp_re_q        <= cp_re_d;
      save_ack_q     <= save_ack_d;
      save_page_q    <= save_page_d;
      restore_done_q <= restore_done_d;
      restore_err_q  <= restore_err_d;
      main_stall_q   <= main_stall_d;
      full_q         <= full_d;
      free_count_q   <= free_count_d;
    end
  end

  assign save_ack     = save_ack_q;
  assign save_page    = save_page_q;
  assign restore_done = restore_done_q;
  assign restore_err  = restore_err_q;
  assign cp_we        = cp_we_q;
  assign cp_re        = cp_re_q;
  assign cp_page      = cp_page_q;
  assign cp_chunk     = cp_chunk_q;
  assign main_stall   = main_stall_q;
  assign full         = full_q;
  assign free_count   = free_count_q;

endmodule

// File: tb/tb_chkpt_ctrl.sv
// Directed bench for chkpt_ctrl: expected copy beats and pulses are queued with
// their due cycle when stimulus is driven and matched by a negedge monitor.
module tb_chkpt_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       save_req = 1'b0, restore_req = 1'b0, release_req = 1'b0, flush = 1'b0;
  logic [2:0] restore_page = '0, release_page = '0;
  logic       save_ack, restore_done, restore_err, cp_we, cp_re, main_stall, full;
  logic [2:0] save_page, cp_page, cp_chunk;
  logic [3:0] free_count;

  chkpt_ctrl #(.NUM_PAGES(8), .NUM_CHUNKS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .save_req     (save_req),
    .save_ack     (save_ack),
    .save_page    (save_page),
    .restore_req  (restore_req),
    .restore_page (restore_page),
    .restore_done (restore_done),
    .restore_err  (restore_err),
    .release_req  (release_req),
    .release_page (release_page),
    .flush        (flush),
    .cp_we        (cp_we),
    .cp_re        (cp_re),
    .cp_page      (cp_page),
    .cp_chunk     (cp_chunk),
    .main_stall   (main_stall),
    .full         (full),
    .free_count   (free_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    int         cyc;
    logic [7:0] val;
  } exp_t;

  exp_t beat_q[$];
  exp_t ack_q[$];
  exp_t done_q[$];
  exp_t err_q[$];
  exp_t mon_e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int pending();
    return beat_q.size() + ack_q.size() + done_q.size() + err_q.size();
  endfunction

  task automatic push_beats(input int a, input bit is_save, input int page, input int n);
    exp_t e;
    for (int c = 0; c < n; c++) begin
      e.cyc = a + c;
      e.val = {is_save, ~is_save, 3'(page), 3'(c)};
      beat_q.push_back(e);
    end
  endtask

  task automatic push_save(input int a, input int page);
    exp_t e;
    push_beats(a, 1'b1, page, 8);
    e.cyc = a + 8;
    e.val = 8'(page);
    ack_q.push_back(e);
  endtask

  task automatic push_restore(input int a, input int page);
    exp_t e;
    push_beats(a, 1'b0, page, 8);
    e.cyc = a + 8;
    e.val = 8'd0;
    done_q.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (pending() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("queues_drained", 32'(pending()), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    save_req = 1'b0; restore_req = 1'b0; release_req = 1'b0; flush = 1'b0;
    beat_q.delete(); ack_q.delete(); done_q.delete(); err_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Single save ending on the negedge of the ack cycle, request dropped there.
  task automatic do_save(input int page);
    int k;
    k = cyc;
    save_req = 1'b1;
    push_save(k + 1, page);
    wait_cyc(k + 9);
    save_req = 1'b0;
  endtask

  task automatic do_restore(input int page);
    int k;
    k = cyc;
    restore_req  = 1'b1;
    restore_page = 3'(page);
    push_restore(k + 1, page);
    step();
    restore_req = 1'b0;
    wait_cyc(k + 9);
  endtask

  task automatic pulse_release(input int page);
    release_req  = 1'b1;
    release_page = 3'(page);
    step();
    release_req = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("we_re_exclusive", 32'(cp_we & cp_re), 0);
      if (cp_we || cp_re) begin
        check("beat_expected", 32'(beat_q.size() != 0), 1);
        if (beat_q.size() != 0) begin
          mon_e = beat_q.pop_front();
          check("beat_value", 32'({cp_we, cp_re, cp_page, cp_chunk}), 32'(mon_e.val));
          check("beat_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("idle_addr_zero", 32'({cp_page, cp_chunk}), 0);
      end
      if (save_ack) begin
        check("ack_expected", 32'(ack_q.size() != 0), 1);
        if (ack_q.size() != 0) begin
          mon_e = ack_q.pop_front();
          check("save_page", 32'(save_page), 32'(mon_e.val));
          check("ack_cycle", cyc, mon_e.cyc);
        end
      end
      if (restore_done) begin
        check("done_expected", 32'(done_q.size() != 0), 1);
        if (done_q.size() != 0) begin
          mon_e = done_q.pop_front();
          check("done_cycle", cyc, mon_e.cyc);
        end
      end
      if (restore_err) begin
        check("err_expected", 32'(err_q.size() != 0), 1);
        if (err_q.size() != 0) begin
          mon_e = err_q.pop_front();
          check("err_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int   k, a, r;
    exp_t e;

    // Reset state and a single save, with a release of the SAVING page ignored.
    do_reset();
    check("rst_free_count", 32'(free_count), 8);
    check("rst_full", 32'(full), 0);
    check("rst_pulses", 32'({save_ack, restore_done, restore_err, cp_we, cp_re, main_stall}), 0);
    check("rst_addr", 32'({cp_page, cp_chunk}), 0);
    k = cyc;
    save_req = 1'b1;
    push_save(k + 1, 0);
    wait_cyc(k + 2);
    pulse_release(0);
    wait_cyc(k + 4);
    check("save_stall", 32'(main_stall), 1);
    wait_cyc(k + 9);
    save_req = 1'b0;
    check("save1_free_count", 32'(free_count), 7);
    check("save1_full", 32'(full), 0);
    step();
    check("save1_idle_stall", 32'(main_stall), 0);
    wait_drain();

    // Back-to-back saves fill every page; a ninth waits for a release.
    do_reset();
    k = cyc;
    save_req = 1'b1;
    for (int i = 0; i < 8; i++) push_save(k + 1 + 9 * i, i);
    wait_cyc(k + 73);
    check("fill_full", 32'(full), 1);
    check("fill_free_count", 32'(free_count), 0);
    wait_cyc(k + 76);
    r = cyc;
    push_save(r + 2, 3);
    pulse_release(3);
    check("rel_free_count", 32'(free_count), 1);
    check("rel_full", 32'(full), 0);
    wait_cyc(r + 10);
    save_req = 1'b0;
    step();
    check("refill_full", 32'(full), 1);
    check("refill_free_count", 32'(free_count), 0);
    wait_drain();

    // Restore a VALID page, then restore FREE pages for errors.
    do_reset();
    do_save(0);
    step();
    do_restore(0);
    check("restore_keeps_valid", 32'(free_count), 7);
    step();
    k = cyc;
    restore_req  = 1'b1;
    restore_page = 3'd5;
    e.cyc = k + 1; e.val = 8'd0; err_q.push_back(e);
    step();
    restore_req = 1'b0;
    check("err_no_stall", 32'(main_stall), 0);
    step();
    pulse_release(0);
    check("release_valid_free", 32'(free_count), 8);
    k = cyc;
    restore_req  = 1'b1;
    restore_page = 3'd0;
    e.cyc = k + 1; e.val = 8'd0; err_q.push_back(e);
    step();
    restore_req = 1'b0;
    wait_drain();

    // Restore request at chunk 4 of a save aborts it and frees the page.
    do_reset();
    do_save(0);
    step();
    k = cyc;
    a = k + 1;
    save_req = 1'b1;
    push_beats(a, 1'b1, 1, 5);
    wait_cyc(a + 4);
    save_req     = 1'b0;
    restore_req  = 1'b1;
    restore_page = 3'd0;
    push_restore(a + 5, 0);
    step();
    restore_req = 1'b0;
    wait_cyc(a + 13);
    check("abort_free_count", 32'(free_count), 7);
    step();
    do_save(1);
    check("abort_realloc_count", 32'(free_count), 6);
    wait_drain();

    // Flush during the fifth save with four VALID pages.
    do_reset();
    k = cyc;
    save_req = 1'b1;
    for (int i = 0; i < 4; i++) push_save(k + 1 + 9 * i, i);
    a = k + 37;
    push_beats(a, 1'b1, 4, 3);
    wait_cyc(a + 2);
    flush    = 1'b1;
    save_req = 1'b0;
    step();
    flush = 1'b0;
    check("flush_stall", 32'(main_stall), 0);
    check("flush_we", 32'(cp_we), 0);
    check("flush_free_count", 32'(free_count), 8);
    check("flush_full", 32'(full), 0);
    repeat (12) step();
    wait_drain();

    // Asynchronous reset during chunk 2 of a restore.
    do_reset();
    do_save(0);
    step();
    k = cyc;
    r = k + 1;
    restore_req  = 1'b1;
    restore_page = 3'd0;
    push_beats(r, 1'b0, 0, 2);
    step();
    restore_req = 1'b0;
    wait_cyc(r + 1);
    @(posedge clk);
    #2;
    check("pre_reset_chunk", 32'({cp_re, cp_chunk}), 32'h0a);
    reset = 1'b1;
    #1;
    check("async_rst_strobes", 32'({cp_we, cp_re, restore_done, save_ack}), 0);
    check("async_rst_addr", 32'({cp_page, cp_chunk}), 0);
    check("async_rst_stall", 32'(main_stall), 0);
    check("async_rst_free", 32'(free_count), 8);
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    check("post_rst_free", 32'(free_count), 8);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
